pcpi_matrix_driver: RTL and testbench
=====================================

Name: pcpi_matrix_driver

Overview:
- PCPI initiator for the fused systolic matrix coprocessor: formats and issues its custom-0 instructions (opcode 7'b0001011).
- Replaces a RISC-V core on the TinyTapeout build, where the host supplies entries and run requests over a simple valid/ready port.
- Sequences load (funct3 000), compute (funct3 111) and clear (funct3 101), waits on the coprocessor's wait/ready handshake, and reports completion or timeout.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in each wait state before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  host load request
- cmd_ready  out  1  load request accepted this cycle
- cmd_addr  in  5  coprocessor address: 0-8 A, 9-17 B, 18-26 bias, 27 threshold
- cmd_data  in  16  signed value
- run_valid  in  1  host compute request
- run_ready  out  1  compute request accepted this cycle
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at end of a run
- timeout  out  1  one-cycle pulse, coincident with done, when the run aborted
- result  out  32  pcpi_rd captured at completion
- pcpi_valid  out  1  instruction valid
- pcpi_insn  out  32  instruction word
- pcpi_wr  in  1  coprocessor write-back flag
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor busy
- pcpi_ready  in  1  coprocessor done

Behaviour:
- Reset values: pcpi_valid=0, pcpi_insn=0, cmd_ready=0, run_ready=0, busy=0, done=0, timeout=0, result=0. All outputs are registered.
- Instruction format: insn[6:0]=7'b0001011, [11:7]=addr, [14:12]=funct3, [30:15]=value, [31]=0. For start and clear, addr and value are 0.
- States and transitions:
  - IDLE: cmd_ready and run_ready are combinationally high only in IDLE. If cmd_valid, accept and go to WRITE. Else if run_valid, accept and go to START.
  - Simultaneous cmd_valid and run_valid: the load wins; run_ready stays 0.
  - WRITE: pcpi_valid=1 for exactly one cycle with funct3 000, addr=cmd_addr and value=cmd_data as latched at accept. Then go to IDLE.
  - Back-to-back loads: one load every 2 cycles.
  - Addresses 28-31 are forwarded unchanged; the coprocessor ignores them.
  - START: pcpi_valid=1 for one cycle with funct3 111. Then go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY: pcpi_ready is ignored, because it is high before compute begins. When pcpi_wait=1, go to WAIT_DONE and clear the counter.
  - WAIT_DONE: on the first cycle with pcpi_ready=1 and pcpi_wait=0, set result<=pcpi_rd and go to CLEAR.
  - CLEAR: pcpi_valid=1 for one cycle with funct3 101. Then go to DONE.
  - DONE: done=1 for one cycle, with timeout=1 if the run aborted. Then go to IDLE.
- Timeout: the counter is 8 bits or wider and counts cycles in WAIT_BUSY and in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, set the abort flag and go to CLEAR.
  - result keeps its previous value.
  - The abort flag clears on the next run accept.
- pcpi_valid is never high for two consecutive cycles.
- pcpi_insn holds its last value while pcpi_valid=0.
- pcpi_wr is not used for control.
- Reset mid-operation: state returns to IDLE and pcpi_valid drops on the next edge. No clear instruction is issued.
- Coprocessor run latency is about 9 cycles. Nominal total from run accept to done is 12-14 cycles.

Optional Feature:
- Macro: DRV_CYCLE_COUNT_EN.
- Defined: adds output run_cycles[15:0], reset 0.
  - Latched in the DONE state with the number of cycles from the START cycle, inclusive, to the DONE cycle, exclusive.
  - Saturates at 16'hFFFF.
  - On timeout, the latched value is the count at abort.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Load: cmd_addr=5, cmd_data=16'h1234 -> next cycle pcpi_valid=1 for one cycle with pcpi_insn=32'h091A028B; busy=1 for one cycle.
- Full load plus run against the real coprocessor:
  - Stimulus: 28 loads with A=I, B=all 2, bias=0, threshold=1.
  - Response: pcpi_insn=32'h0000700B at start, then 32'h0000500B at clear; done pulse with timeout=0; run_cycles between 12 and 14 when DRV_CYCLE_COUNT_EN is defined.
- Simultaneous cmd_valid and run_valid in IDLE -> cmd_ready=1, run_ready=0; WRITE is issued first and the run is accepted 2 cycles later.
- Coprocessor model holds pcpi_wait=0 forever -> after 64 WAIT_BUSY cycles, the clear instruction 32'h0000500B, then done=1 and timeout=1; result unchanged.
- Model returns pcpi_rd=32'hDEADBEEF with pcpi_ready=1 after 8 wait cycles -> result=32'hDEADBEEF when done pulses.
- rst asserted during WAIT_DONE -> next cycle busy=0 and pcpi_valid=0, no done pulse; a subsequent run completes normally.

Source files
------------

// File: rtl/pcpi_matrix_driver.sv
// PCPI initiator for the systolic matrix coprocessor: issues load/compute/clear custom-0 instructions.
// Optional DRV_CYCLE_COUNT_EN adds a run_cycles output with the START-to-DONE cycle count.
module pcpi_matrix_driver #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [4:0]  cmd_addr,
   input  logic [15:0] cmd_data,
   input  logic        run_valid,
   output logic        run_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] result,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_wait,
   input  logic        pcpi_ready
`ifdef DRV_CYCLE_COUNT_EN
   ,output logic [15:0] run_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CLEAR,
      S_DONE
   } state_t;

   localparam logic [6:0] OPCODE  = 7'b0001011;
   localparam logic [2:0] F3_LOAD = 3'b000;
   localparam logic [2:0] F3_RUN  = 3'b111;
   localparam logic [2:0] F3_CLR  = 3'b101;
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;
   logic             abort_q;
   logic [31:0]      result_q;
   logic             valid_q;
   logic [31:0]      insn_q;
   logic [CNT_W-1:0] cnt_q;
   logic             unused_wr;

   function automatic logic [31:0] fmt_insn(input logic [4:0] addr, input logic [2:0] f3,
                                            input logic signed [15:0] val);
      return {1'b0, val, f3, addr, OPCODE};
   endfunction

   // Handshakes are only offered in IDLE; a load request takes priority over a run request.
   assign cmd_ready = !rst && (state_q == S_IDLE) && cmd_valid;
   assign run_ready = !rst && (state_q == S_IDLE) && run_valid && !cmd_valid;

   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = timeout_q;
   assign result     = result_q;
   assign pcpi_valid = valid_q;
   assign pcpi_insn  = insn_q;
   assign unused_wr  = pcpi_wr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
         result_q  <= '0;
         valid_q   <= 1'b0;
         insn_q    <= '0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  state_q <= S_WRITE;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b1;
                  insn_q  <= fmt_insn(cmd_addr, F3_LOAD, cmd_data);
               end else if (run_valid) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b1;
                  insn_q  <= fmt_insn(5'd0, F3_RUN, 16'sd0);
                  abort_q <= 1'b0;
               end
            end
            S_WRITE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            S_START: begin
               state_q <= S_WAIT_BUSY;
               cnt_q   <= '0;
            end
            // pcpi_ready is stale-high before the compute begins, so only wait is trusted here.
            S_WAIT_BUSY: begin
               if (pcpi_wait) begin
                  state_q <= S_WAIT_DONE;
                  cnt_q   <= '0;
               end else if (cnt_q == TO_LAST) begin
                  abort_q <= 1'b1;
                  state_q <= S_CLEAR;
                  valid_q <= 1'b1;
                  insn_q  <= fmt_insn(5'd0, F3_CLR, 16'sd0);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (pcpi_ready && !pcpi_wait) begin
                  result_q <= pcpi_rd;
                  state_q  <= S_CLEAR;
                  valid_q  <= 1'b1;
                  insn_q   <= fmt_insn(5'd0, F3_CLR, 16'sd0);
               end else if (cnt_q == TO_LAST) begin
                  abort_q <= 1'b1;
                  state_q <= S_CLEAR;
                  valid_q <= 1'b1;
                  insn_q  <= fmt_insn(5'd0, F3_CLR, 16'sd0);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_CLEAR: begin
               state_q   <= S_DONE;
               done_q    <= 1'b1;
               timeout_q <= abort_q;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DRV_CYCLE_COUNT_EN
   logic [15:0] cyc_q;
   logic [15:0] run_cycles_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign run_cycles = run_cycles_q;

   // Latching on the CLEAR edge includes the CLEAR cycle and makes the count visible alongside done.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q        <= '0;
         run_cycles_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (run_ready) cyc_q <= '0;
            S_START, S_WAIT_BUSY, S_WAIT_DONE: cyc_q <= sat_inc(cyc_q);
            S_CLEAR: run_cycles_q <= sat_inc(cyc_q);
            default: cyc_q <= cyc_q;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_pcpi_matrix_driver.sv
// Directed bench for pcpi_matrix_driver with a small latency-programmable coprocessor model.
module tb_pcpi_matrix_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        run_valid;
   logic        run_ready;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] result;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic        pcpi_wr;
   logic [31:0] cp_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;
`ifdef DRV_CYCLE_COUNT_EN
   logic [15:0] run_cycles;
   logic [15:0] rc_at_done;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cp_mode;
   int cp_lat;
   int cp_cnt;

   always #5 clk = ~clk;

   pcpi_matrix_driver #(.TIMEOUT_CYCLES(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .run_valid  (run_valid),
      .run_ready  (run_ready),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .result     (result),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_wr    (pcpi_wr),
      .pcpi_rd    (cp_rd),
      .pcpi_wait  (pcpi_wait),
      .pcpi_ready (pcpi_ready)
`ifdef DRV_CYCLE_COUNT_EN
      ,.run_cycles (run_cycles)
`endif
   );

   // Coprocessor: on a start instruction, wait is high for cp_lat cycles, then ready with cp_rd.
   always @(posedge clk) begin
      if (rst) begin
         pcpi_wait  <= 1'b0;
         pcpi_ready <= 1'b1;
         cp_cnt     <= 0;
      end else if (cp_mode == 1 && pcpi_valid && pcpi_insn == 32'h0000700B) begin
         pcpi_wait  <= 1'b1;
         pcpi_ready <= 1'b0;
         cp_cnt     <= cp_lat;
      end else if (cp_cnt > 1) begin
         cp_cnt <= cp_cnt - 1;
      end else if (cp_cnt == 1) begin
         cp_cnt     <= 0;
         pcpi_wait  <= 1'b0;
         pcpi_ready <= 1'b1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic do_load(input logic [4:0] a, input logic [15:0] d);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic start_run(input string tag);
      @(negedge clk);
      run_valid = 1'b1;
      #1;
      check_val({tag, "_run_ready"}, {31'd0, run_ready}, 32'd1);
      @(negedge clk);
      run_valid = 1'b0;
      check_val({tag, "_start_valid"}, {31'd0, pcpi_valid}, 32'd1);
      check_val({tag, "_start_insn"}, pcpi_insn, 32'h0000700B);
   endtask

   task automatic wait_done(output logic got_done, output logic got_to, output logic [31:0] got_res,
                            output int cyc, output int n_clr, output int n_dbl);
      logic prev_v;
      prev_v   = pcpi_valid;
      got_done = 1'b0;
      got_to   = 1'b0;
      got_res  = '0;
      cyc      = 0;
      n_clr    = 0;
      n_dbl    = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (pcpi_valid && prev_v) n_dbl++;
         if (pcpi_valid && pcpi_insn == 32'h0000500B) n_clr++;
         prev_v = pcpi_valid;
         if (done) begin
            got_done = 1'b1;
            got_to   = timeout;
            got_res  = result;
            cyc      = i;
`ifdef DRV_CYCLE_COUNT_EN
            rc_at_done = run_cycles;
`endif
            break;
         end
      end
   endtask

   logic        g_done;
   logic        g_to;
   logic [31:0] g_res;
   int          g_cyc;
   int          g_clr;
   int          g_dbl;
   int          n_done_seen;
   int          n_valid_seen;
   logic [15:0] ld_data;

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      run_valid = 1'b0;
      pcpi_wr   = 1'b0;
      cp_mode   = 1;
      cp_lat    = 9;
      cp_rd     = 32'h00000123;
      repeat (3) @(negedge clk);
      check_val("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
      check_val("rst_pcpi_insn", pcpi_insn, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_timeout", {31'd0, timeout}, 32'd0);
      check_val("rst_result", result, 32'd0);
      check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check_val("rst_run_ready", {31'd0, run_ready}, 32'd0);
`ifdef DRV_CYCLE_COUNT_EN
      check_val("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
`endif
      rst = 1'b0;

      // Single load and its one-cycle instruction
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = 5'd5;
      cmd_data  = 16'h1234;
      #1;
      check_val("load_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("load_run_ready", {31'd0, run_ready}, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("load_valid", {31'd0, pcpi_valid}, 32'd1);
      check_val("load_insn", pcpi_insn, 32'h091A028B);
      check_val("load_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check_val("load_valid_drop", {31'd0, pcpi_valid}, 32'd0);
      check_val("load_busy_drop", {31'd0, busy}, 32'd0);
      check_val("load_insn_hold", pcpi_insn, 32'h091A028B);

      // 28 loads: A = identity, B = 2, bias = 0, threshold = 1
      for (int a = 0; a < 28; a++) begin
         if (a < 9) ld_data = (a == 0 || a == 4 || a == 8) ? 16'd1 : 16'd0;
         else if (a < 18) ld_data = 16'd2;
         else if (a < 27) ld_data = 16'd0;
         else ld_data = 16'd1;
         do_load(5'(a), ld_data);
         if (a == 27) check_val("load27_insn", pcpi_insn, 32'h00008D8B);
      end
      do_load(5'd30, 16'h8001);
      check_val("load30_insn", pcpi_insn, 32'h40008F0B);

      start_run("run1");
      wait_done(g_done, g_to, g_res, g_cyc, g_clr, g_dbl);
      check_val("run1_done", {31'd0, g_done}, 32'd1);
      check_val("run1_timeout", {31'd0, g_to}, 32'd0);
      check_val("run1_result", g_res, 32'h00000123);
      check_val("run1_cycles", 32'(g_cyc), 32'd12);
      check_val("run1_clear", 32'(g_clr), 32'd1);
      check_val("run1_no_dbl", 32'(g_dbl), 32'd0);
`ifdef DRV_CYCLE_COUNT_EN
      check_val("run1_run_cycles", {16'd0, rc_at_done}, 32'd12);
`endif
      @(negedge clk);
      check_val("run1_done_pulse", {31'd0, done}, 32'd0);
      check_val("run1_busy_drop", {31'd0, busy}, 32'd0);

      // Coprocessor never raises wait: abort after 64 WAIT_BUSY cycles
      cp_mode = 0;
      cp_rd   = 32'h11111111;
      start_run("to");
      wait_done(g_done, g_to, g_res, g_cyc, g_clr, g_dbl);
      check_val("to_done", {31'd0, g_done}, 32'd1);
      check_val("to_timeout", {31'd0, g_to}, 32'd1);
      check_val("to_result_kept", g_res, 32'h00000123);
      check_val("to_cycles", 32'(g_cyc), 32'd66);
      check_val("to_clear", 32'(g_clr), 32'd1);
`ifdef DRV_CYCLE_COUNT_EN
      check_val("to_run_cycles", {16'd0, rc_at_done}, 32'd66);
`endif

      // Simultaneous load and run: load first, run accepted two cycles later
      cp_mode = 1;
      cp_lat  = 8;
      cp_rd   = 32'hDEADBEEF;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = 5'd3;
      cmd_data  = 16'hFFFF;
      run_valid = 1'b1;
      #1;
      check_val("sim_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_val("sim_run_ready", {31'd0, run_ready}, 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("sim_load_insn", pcpi_insn, 32'h7FFF818B);
      check_val("sim_run_ready_write", {31'd0, run_ready}, 32'd0);
      @(negedge clk);
      #1;
      check_val("sim_run_ready_idle", {31'd0, run_ready}, 32'd1);
      @(negedge clk);
      run_valid = 1'b0;
      check_val("sim_start_insn", pcpi_insn, 32'h0000700B);
      wait_done(g_done, g_to, g_res, g_cyc, g_clr, g_dbl);
      check_val("beef_done", {31'd0, g_done}, 32'd1);
      check_val("beef_timeout", {31'd0, g_to}, 32'd0);
      check_val("beef_result", g_res, 32'hDEADBEEF);
      check_val("beef_cycles", 32'(g_cyc), 32'd11);

      // Reset in WAIT_DONE, then a clean run
      cp_lat = 9;
      cp_rd  = 32'hCAFE0001;
      start_run("rr");
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("rr_busy", {31'd0, busy}, 32'd0);
      check_val("rr_valid", {31'd0, pcpi_valid}, 32'd0);
      n_done_seen  = 0;
      n_valid_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) n_done_seen++;
         if (pcpi_valid) n_valid_seen++;
      end
      check_val("rr_no_done", 32'(n_done_seen), 32'd0);
      check_val("rr_no_clear", 32'(n_valid_seen), 32'd0);
      start_run("rr2");
      wait_done(g_done, g_to, g_res, g_cyc, g_clr, g_dbl);
      check_val("rr2_done", {31'd0, g_done}, 32'd1);
      check_val("rr2_timeout", {31'd0, g_to}, 32'd0);
      check_val("rr2_result", g_res, 32'hCAFE0001);
      check_val("rr2_cycles", 32'(g_cyc), 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
